tap_shift_buffer: RTL and testbench

TAP_SHIFT_BUFFER -- requirements
Module: tap_shift_buffer

---
 rtl/tap_shift_buffer_pkg.sv | 23 ++
 rtl/tap_shift_buffer_if.sv | 62 ++++++
 rtl/tap_shift_sum.sv | 48 ++++
 rtl/tap_shift_buffer.sv | 109 ++++++++++
 tb/tb_tap_shift_buffer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/tap_shift_buffer_pkg.sv
// Shared types and width helpers for the tap shift buffer.
//
// Contents:
//   tap_state_e  : window fill state (EMPTY, FILLING, FULL)
//   calc_aw()    : tap address width, max(1, ceil(log2(depth)))
//   calc_cw()    : fill count width, ceil(log2(depth+1))
package tap_shift_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } tap_state_e;

    function automatic int calc_aw(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int calc_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tap_shift_buffer_if.sv
// Bus bundle between a tap shift buffer and its user.
//
// Handshake: there is no back-pressure. A sample is accepted on every rising
// clk edge where load_in_sync=1; the buffer is always ready. flush may be
// combined with load_in_sync on the same edge (clear, then insert).
//
// Signals:
//   load_in_sync, flush, data_in, rd_addr      : user -> buffer
//   rd_data, rd_addr_err                        : buffer -> user, combinational
//   fill_count, window_empty, window_full, state: buffer -> user, registered
//   sum_out                                     : running sum, only when
//                                                 TAP_SHIFT_SUM_EN is defined
//
// Modports: master = user side, slave = buffer side.
interface tap_shift_buffer_if
    import tap_shift_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 8
);
    localparam int AW = calc_aw(DEPTH);
    localparam int CW = calc_cw(DEPTH);

    logic                         load_in_sync;
    logic                         flush;
    logic signed [DATA_WIDTH-1:0] data_in;
    logic [AW-1:0]                rd_addr;
    logic signed [DATA_WIDTH-1:0] rd_data;
    logic                         rd_addr_err;
    logic [CW-1:0]                fill_count;
    logic                         window_empty;
    logic                         window_full;
    tap_state_e                   state;
`ifdef TAP_SHIFT_SUM_EN
    logic signed [DATA_WIDTH+AW-1:0] sum_out;
`endif

`ifdef TAP_SHIFT_SUM_EN
    modport master (
        output load_in_sync, flush, data_in, rd_addr,
        input  rd_data, rd_addr_err, fill_count, window_empty, window_full,
               state, sum_out
    );
    modport slave (
        input  load_in_sync, flush, data_in, rd_addr,
        output rd_data, rd_addr_err, fill_count, window_empty, window_full,
               state, sum_out
    );
`else
    modport master (
        output load_in_sync, flush, data_in, rd_addr,
        input  rd_data, rd_addr_err, fill_count, window_empty, window_full,
               state
    );
    modport slave (
        input  load_in_sync, flush, data_in, rd_addr,
        output rd_data, rd_addr_err, fill_count, window_empty, window_full,
               state
    );
`endif

endinterface

// File: rtl/tap_shift_sum.sv
// Running sum of all taps in the shift window.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : a new sample enters the window this edge
//   flush      : window cleared this edge (load wins for tap 0)
//   data_in    : incoming sample
//   oldest     : current last tap, leaving the window on a load
//   sum_out    : registered signed sum, DATA_WIDTH+AW bits
//
// The sum is kept incrementally: add the entering sample and subtract the
// leaving one. The leaving tap is zero until the window is full, so no
// special case is needed while filling. AW guard bits cover DEPTH samples.
module tap_shift_sum
    import tap_shift_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      load,
    input  logic                                      flush,
    input  logic signed [DATA_WIDTH-1:0]              data_in,
    input  logic signed [DATA_WIDTH-1:0]              oldest,
    output logic signed [DATA_WIDTH+calc_aw(DEPTH)-1:0] sum_out
);
    localparam int AW = calc_aw(DEPTH);
    localparam int SW = DATA_WIDTH + AW;

    logic signed [SW-1:0] in_ext;
    logic signed [SW-1:0] old_ext;

    assign in_ext  = {{AW{data_in[DATA_WIDTH-1]}}, data_in};
    assign old_ext = {{AW{oldest[DATA_WIDTH-1]}}, oldest};

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_out <= '0;
        end else if (load) begin
            // After a flush+load only the new sample remains in the window.
            sum_out <= flush ? in_ext : (sum_out + in_ext - old_ext);
        end else if (flush) begin
            sum_out <= '0;
        end
    end

endmodule

// File: rtl/tap_shift_buffer.sv
// Tap shift buffer: a DEPTH-deep window of signed samples with random read
// access, a fill counter, EMPTY/FILLING/FULL state and an optional running
// sum (enabled by defining TAP_SHIFT_SUM_EN).
//
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset, overrides flush and load
//   bus  : tap_shift_buffer_if.slave (see interface for signal list)
//
// Tap 0 is the newest sample. Reads are combinational from the registered
// taps; an out-of-range rd_addr reads 0 and raises rd_addr_err.
module tap_shift_buffer
    import tap_shift_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 8
) (
    input logic               clk,
    input logic               rst,
    tap_shift_buffer_if.slave bus
);
    localparam int AW = calc_aw(DEPTH);
    localparam int CW = calc_cw(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic signed [DATA_WIDTH-1:0] taps [DEPTH];
    logic [CW-1:0]                fill_q;
    tap_state_e                   state_q;
    tap_state_e                   state_d;

    // Tap storage. Unfilled taps hold 0 because every clear path zeroes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) taps[k] <= '0;
        end else if (bus.load_in_sync) begin
            taps[0] <= bus.data_in;
            for (int k = 1; k < DEPTH; k++) taps[k] <= bus.flush ? '0 : taps[k-1];
        end else if (bus.flush) begin
            for (int k = 0; k < DEPTH; k++) taps[k] <= '0;
        end
    end

    // Fill counter saturates at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
        end else if (bus.load_in_sync) begin
            if (bus.flush)                fill_q <= CW'(1);
            else if (fill_q != FULL_COUNT) fill_q <= fill_q + CW'(1);
        end else if (bus.flush) begin
            fill_q <= '0;
        end
    end

    // Window state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.load_in_sync) begin
            if (bus.flush) begin
                state_d = FILLING;
            end else begin
                case (state_q)
                    EMPTY:   state_d = FILLING;
                    // The load that brings the count to DEPTH enters FULL.
                    FILLING: state_d = (fill_q == FULL_COUNT - CW'(1)) ? FULL : FILLING;
                    FULL:    state_d = FULL;
                    default: state_d = EMPTY;
                endcase
            end
        end else if (bus.flush) begin
            state_d = EMPTY;
        end
    end

    // Combinational read port.
    always_comb begin
        bus.rd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (bus.rd_addr == AW'(k)) bus.rd_data = taps[k];
        end
    end

    assign bus.rd_addr_err  = (32'(bus.rd_addr) >= DEPTH);
    assign bus.fill_count   = fill_q;
    assign bus.window_empty = (state_q == EMPTY);
    assign bus.window_full  = (state_q == FULL);
    assign bus.state        = state_q;

`ifdef TAP_SHIFT_SUM_EN
    tap_shift_sum #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_sum (
        .clk     (clk),
        .rst     (rst),
        .load    (bus.load_in_sync),
        .flush   (bus.flush),
        .data_in (bus.data_in),
        .oldest  (taps[DEPTH-1]),
        .sum_out (bus.sum_out)
    );
`endif

endmodule

// File: tb/tb_tap_shift_buffer.sv
// Directed bench for tap_shift_buffer (DEPTH=8 and DEPTH=6 instances).
// Running-sum checks are compiled in when TAP_SHIFT_SUM_EN is defined.
module tb_tap_shift_buffer;
    import tap_shift_pkg::*;

    logic clk;
    logic rst;

    tap_shift_buffer_if #(.DATA_WIDTH(12), .DEPTH(8)) bus8();
    tap_shift_buffer_if #(.DATA_WIDTH(12), .DEPTH(6)) bus6();

    tap_shift_buffer #(.DATA_WIDTH(12), .DEPTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    tap_shift_buffer #(.DATA_WIDTH(12), .DEPTH(6)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counters and scoreboard
    int          total_cnt;
    int          pass_cnt;
    logic [31:0] exp_q[$];

    // Reference model of the DEPTH=8 window
    int m_taps[8];
    int m_fill;
    int m_sum;

    task automatic check(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void model_clear();
        for (int k = 0; k < 8; k++) m_taps[k] = 0;
        m_fill = 0;
        m_sum  = 0;
    endfunction

    function automatic void model_load(input int d, input bit fl);
        m_sum = fl ? d : (m_sum + d - m_taps[7]);
        for (int k = 7; k >= 1; k--) m_taps[k] = fl ? 0 : m_taps[k-1];
        m_taps[0] = d;
        m_fill = fl ? 1 : ((m_fill < 8) ? m_fill + 1 : 8);
    endfunction

    // Drive one load edge; expected fill count is queued at drive time and
    // popped once the DUT has taken the edge.
    task automatic load8(input int d, input bit fl);
        bus8.data_in      = 12'(d);
        bus8.load_in_sync = 1'b1;
        bus8.flush        = fl;
        model_load(d, fl);
        exp_q.push_back(32'(m_fill));
        @(posedge clk);
        #1;
        bus8.load_in_sync = 1'b0;
        bus8.flush        = 1'b0;
        check("fill_count", int'(bus8.fill_count), int'(exp_q.pop_front()));
    endtask

    task automatic check_taps8(input string tag);
        for (int a = 0; a < 8; a++) begin
            bus8.rd_addr = 3'(a);
            #1;
            check($sformatf("%s_tap%0d", tag, a), int'(bus8.rd_data), m_taps[a]);
        end
    endtask

    task automatic check_flags8(input string tag);
        check({tag, "_empty"}, int'(bus8.window_empty), (m_fill == 0) ? 1 : 0);
        check({tag, "_full"},  int'(bus8.window_full),  (m_fill == 8) ? 1 : 0);
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        model_clear();
        rst               = 1'b1;
        bus8.load_in_sync = 1'b0;
        bus8.flush        = 1'b0;
        bus8.data_in      = '0;
        bus8.rd_addr      = '0;
        bus6.load_in_sync = 1'b0;
        bus6.flush        = 1'b0;
        bus6.data_in      = '0;
        bus6.rd_addr      = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_fill", int'(bus8.fill_count), 0);
        check_flags8("rst");
        check("rst_state", int'(bus8.state), int'(EMPTY));
        check_taps8("rst");
`ifdef TAP_SHIFT_SUM_EN
        check("rst_sum", int'(bus8.sum_out), 0);
`endif

        // Fill with 1..8
        for (int i = 1; i <= 8; i++) begin
            load8(i, 1'b0);
            check_flags8($sformatf("fill%0d", i));
        end
        check("full_state", int'(bus8.state), int'(FULL));
        bus8.rd_addr = 3'd0;
        #1;
        check("newest_is_8", int'(bus8.rd_data), 8);
        bus8.rd_addr = 3'd7;
        #1;
        check("oldest_is_1", int'(bus8.rd_data), 1);
        check("rd_err_8", int'(bus8.rd_addr_err), 0);
`ifdef TAP_SHIFT_SUM_EN
        check("sum_36", int'(bus8.sum_out), 36);
`endif

        // Shift on a full window
        load8(9, 1'b0);
        bus8.rd_addr = 3'd7;
        #1;
        check("tap7_is_2", int'(bus8.rd_data), 2);
        check_flags8("load9");
`ifdef TAP_SHIFT_SUM_EN
        check("sum_44", int'(bus8.sum_out), 44);
`endif

        // Extreme values
        load8(-2048, 1'b0);
        for (int i = 0; i < 7; i++) load8(2047, 1'b0);
        check_taps8("extreme");
`ifdef TAP_SHIFT_SUM_EN
        check("sum_12281", int'(bus8.sum_out), 12281);
`endif
        load8(-2048, 1'b0);
`ifdef TAP_SHIFT_SUM_EN
        check("sum_hold_12281", int'(bus8.sum_out), 12281);
`endif
        check_taps8("swap");

        // Idle cycles hold everything even with data_in moving
        for (int i = 0; i < 3; i++) begin
            bus8.data_in = 12'($urandom_range(0, 4095));
            @(posedge clk);
            #1;
        end
        check("idle_fill", int'(bus8.fill_count), 8);
        check_taps8("idle");

        // Flush and load on the same edge
        load8(5, 1'b1);
        check_taps8("flushload");
        check("flushload_state", int'(bus8.state), int'(FILLING));
        check_flags8("flushload");
`ifdef TAP_SHIFT_SUM_EN
        check("flushload_sum", int'(bus8.sum_out), 5);
`endif

        // Flush alone
        bus8.flush = 1'b1;
        @(posedge clk);
        #1;
        bus8.flush = 1'b0;
        model_clear();
        check("flush_fill", int'(bus8.fill_count), 0);
        check("flush_state", int'(bus8.state), int'(EMPTY));
        check_flags8("flush");
        check_taps8("flush");

        // Reset mid-fill with load held high
        load8(1, 1'b0);
        load8(2, 1'b0);
        load8(3, 1'b0);
        bus8.load_in_sync = 1'b1;
        bus8.data_in      = 12'd77;
        rst               = 1'b1;
        @(posedge clk);
        #1;
        rst               = 1'b0;
        bus8.load_in_sync = 1'b0;
        model_clear();
        check("midrst_fill", int'(bus8.fill_count), 0);
        check_flags8("midrst");
        check_taps8("midrst");
        load8(4, 1'b0);
        check("after_rst_state", int'(bus8.state), int'(FILLING));
        check_taps8("after_rst");

        // DEPTH=6: address bounds
        for (int i = 1; i <= 6; i++) begin
            bus6.data_in      = 12'(i * 10);
            bus6.load_in_sync = 1'b1;
            @(posedge clk);
            #1;
        end
        bus6.load_in_sync = 1'b0;
        check("d6_full", int'(bus6.window_full), 1);
        bus6.rd_addr = 3'd5;
        #1;
        check("d6_addr5_data", int'(bus6.rd_data), 10);
        check("d6_addr5_err", int'(bus6.rd_addr_err), 0);
        bus6.rd_addr = 3'd0;
        #1;
        check("d6_addr0_data", int'(bus6.rd_data), 60);
        bus6.rd_addr = 3'd6;
        #1;
        check("d6_addr6_data", int'(bus6.rd_data), 0);
        check("d6_addr6_err", int'(bus6.rd_addr_err), 1);
        bus6.rd_addr = 3'd7;
        #1;
        check("d6_addr7_data", int'(bus6.rd_data), 0);
        check("d6_addr7_err", int'(bus6.rd_addr_err), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
